opd_sample_fifo: RTL



---
 rtl/opd_sample_fifo.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/opd_sample_fifo.sv
// opd_sample_fifo
// Buffers lock-in results (X, Y) and, optionally, the ADC sample counter in a
// circular buffer. Software pops one entry per level change of rd_toggle_i and
// sees the pop complete when rd_ack_o matches rd_toggle_i.
// Pushes that arrive while the buffer is full are dropped and counted in a
// saturating 16-bit overflow counter.
// Build option: define OPD_FIFO_TIMESTAMP_EN to store count_i with each entry.
// Without it, entries are 64 bits wide and count_o is constant zero.
module opd_sample_fifo #(
    parameter int DEPTH = 64,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          tick_i,
    input  logic [31:0]   x_i,
    input  logic [31:0]   y_i,
    input  logic [31:0]   count_i,
    input  logic          rd_toggle_i,
    output logic          rd_ack_o,
    output logic [31:0]   x_o,
    output logic [31:0]   y_o,
    output logic [31:0]   count_o,
    output logic          valid_o,
    output logic [LW-1:0] level_o,
    output logic [15:0]   overflow_o
);

    localparam int AW = $clog2(DEPTH);
`ifdef OPD_FIFO_TIMESTAMP_EN
    localparam int EW = 96;
`else
    localparam int EW = 64;
`endif

    localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [LW-1:0] LEVEL_ONE = {{(LW-1){1'b0}}, 1'b1};

    // Entry layout: {count (timestamp builds only), x, y}; y sits in [31:0].
    logic [EW-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic [15:0]   overflow_reg;

    logic          rd_prev_reg;
    logic          rd_ack_reg;
    logic          valid_reg;
    logic [31:0]   x_reg;
    logic [31:0]   y_reg;

    logic          empty;
    logic          full;
    logic          pop_req;
    logic          pop;
    logic          push;
    logic          drop;
    logic [EW-1:0] wr_entry;

    assign wr_addr = wr_ptr_reg[AW-1:0];
    assign rd_addr = rd_ptr_reg[AW-1:0];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_addr == rd_addr);

    // A pop request is any level change of the software toggle; it only
    // removes an entry when something is stored (no bypass from a same-cycle push).
    assign pop_req = (rd_toggle_i != rd_prev_reg);
    assign pop     = pop_req && !empty;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push = tick_i && (!full || pop);
    assign drop = tick_i && full && !pop;

`ifdef OPD_FIFO_TIMESTAMP_EN
    assign wr_entry = {count_i, x_i, y_i};
`else
    assign wr_entry = {x_i, y_i};

    // count_i is kept on the port for a uniform top level but is not stored.
    logic unused_count;
    assign unused_count = ^count_i;
`endif

    // Level bookkeeping: +1 on push, -1 on a real pop, unchanged on both.
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LEVEL_ONE;
            2'b01:   level_next = level_reg - LEVEL_ONE;
            default: level_next = level_reg;
        endcase
    end

    // Storage write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    // Pointer, level and drop-counter state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            level_reg <= level_next;
            if (drop && (overflow_reg != 16'hFFFF)) begin
                overflow_reg <= overflow_reg + 16'd1;
            end
        end
    end

    // Toggle edge detector and acknowledge; reset loads the live toggle level
    // so that releasing reset never looks like a read request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_prev_reg <= rd_toggle_i;
            rd_ack_reg  <= rd_toggle_i;
        end else begin
            rd_prev_reg <= rd_toggle_i;
            if (pop_req) begin
                rd_ack_reg <= rd_toggle_i;
            end
        end
    end

    // Registered read port: head entry is captured on a pop; an empty pop
    // only clears valid and leaves the data registers holding their values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else if (pop_req) begin
            valid_reg <= pop;
            if (pop) begin
                x_reg <= mem[rd_addr][63:32];
                y_reg <= mem[rd_addr][31:0];
            end
        end
    end

`ifdef OPD_FIFO_TIMESTAMP_EN
    logic [31:0] count_reg;

    // Timestamp read register, loaded alongside x/y.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_reg <= '0;
        end else if (pop) begin
            count_reg <= mem[rd_addr][95:64];
        end
    end

    assign count_o = count_reg;
`else
    assign count_o = '0;
`endif

    assign rd_ack_o   = rd_ack_reg;
    assign valid_o    = valid_reg;
    assign x_o        = x_reg;
    assign y_o        = y_reg;
    assign level_o    = level_reg;
    assign overflow_o = overflow_reg;

endmodule
